// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared codes, funct values and sequencer states for alu_control_md
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_SLT   = 3'b100;
   localparam logic [2:0] OP_XOR   = 3'b101;
   localparam logic [2:0] OP_ADDI  = 3'b110;
   localparam logic [2:0] OP_RTYPE = 3'b111;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [1:0] HS_ALU = 2'b00;
   localparam logic [1:0] HS_HI  = 2'b01;
   localparam logic [1:0] HS_LO  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_e;

   // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B: bit1 selects divide, bit0 selects unsigned.
   function automatic logic is_md_funct(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/md_seq.sv
// rtl/md_seq.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module md_seq
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_is_div,
   input  logic              i_is_signed,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   output logic              o_busy,
   output logic              o_md_done,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   localparam int CNT_W = $clog2(DATA_W);

   md_state_e r_state, w_next;
   logic [2*DATA_W-1:0] r_acc;
   logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_is_div, r_neg_res, r_neg_rem, r_dz, r_done;

   logic              w_a_neg, w_b_neg, w_dz, w_last, w_ge;
   logic [DATA_W-1:0] w_mag_a, w_mag_b, w_quot, w_rem;
   logic [DATA_W:0]   w_mul_sum, w_shift, w_diff;
   logic [2*DATA_W-1:0] w_prod;

   assign w_a_neg = i_is_signed & i_op_a[DATA_W-1];
   assign w_b_neg = i_is_signed & i_op_b[DATA_W-1];
   assign w_mag_a = w_a_neg ? -i_op_a : i_op_a;
   assign w_mag_b = w_b_neg ? -i_op_b : i_op_b;
   assign w_dz    = i_is_div & (i_op_b == '0);
   assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

   // Multiply: r_a is the multiplier shifted right, r_b the multiplicand.
   // Divide: r_a shifts dividend bits out and quotient bits in; r_acc low half is the remainder.
   assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_a[0] ? {1'b0, r_b} : '0);
   assign w_shift   = {r_acc[DATA_W-1:0], r_a[DATA_W-1]};
   assign w_diff    = w_shift - {1'b0, r_b};
   assign w_ge      = ~w_diff[DATA_W];

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quot = r_neg_res ? -r_a : r_a;
   assign w_rem  = r_neg_rem ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_start) w_next = w_dz ? S_FIX : (i_is_div ? S_DIV : S_MUL);
         S_MUL:  if (w_last) w_next = S_FIX;
         S_DIV:  if (w_last) w_next = S_FIX;
         S_FIX:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: if (i_start) begin
               r_is_div  <= i_is_div;
               r_neg_res <= w_a_neg ^ w_b_neg;
               r_neg_rem <= w_a_neg;
               r_dz      <= w_dz;
               r_cnt     <= '0;
               // On divide-by-zero the raw dividend is parked here for HI.
               r_acc     <= w_dz ? {{DATA_W{1'b0}}, i_op_a} : '0;
               r_a       <= i_is_div ? w_mag_a : w_mag_b;
               r_b       <= i_is_div ? w_mag_b : w_mag_a;
            end
            S_MUL: begin
               r_acc <= {w_mul_sum, r_acc[DATA_W-1:1]};
               r_a   <= r_a >> 1;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DIV: begin
               r_acc[DATA_W-1:0] <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
               r_a   <= {r_a[DATA_W-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               if (r_dz) begin
                  r_hi <= r_acc[DATA_W-1:0];
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[2*DATA_W-1:DATA_W];
                  r_lo <= w_prod[DATA_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy    = (r_state != S_IDLE);
   assign o_md_done = r_done;
   assign o_hi      = r_hi;
   assign o_lo      = r_lo;

endmodule

// File: rtl/alu_control_md.sv
// rtl/alu_control_md.sv - ALU control decode with multiply/divide sequencer and stall interlock
module alu_control_md
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [2:0]        ALUop,
   input  logic [5:0]        function_code,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [CTRL_W-1:0] alu_ctr,
   output logic              illegal,
   output logic [1:0]        hilo_sel,
   output logic              stall,
   output logic              md_done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   logic [3:0] w_code;
   logic       w_illegal, w_rtype, w_md_op, w_busy, w_accept;
   logic [1:0] w_hilo;

   assign w_rtype = (ALUop == OP_RTYPE);

   always_comb begin
      w_code    = ALU_ADD;
      w_illegal = 1'b0;
      w_hilo    = HS_ALU;
      case (ALUop)
         OP_ADD:  w_code = ALU_ADD;
         OP_SUB:  w_code = ALU_SUB;
         OP_AND:  w_code = ALU_AND;
         OP_OR:   w_code = ALU_OR;
         OP_SLT:  w_code = ALU_SLT;
         OP_XOR:  w_code = ALU_XOR;
         OP_ADDI: w_code = ALU_ADD;
         OP_RTYPE: begin
            case (function_code)
               FN_ADD, FN_ADDU: w_code = ALU_ADD;
               FN_SUB, FN_SUBU: w_code = ALU_SUB;
               FN_AND:  w_code = ALU_AND;
               FN_OR:   w_code = ALU_OR;
               FN_XOR:  w_code = ALU_XOR;
               FN_NOR:  w_code = ALU_NOR;
               FN_SLT:  w_code = ALU_SLT;
               FN_SLTU: w_code = ALU_SLTU;
               FN_MFHI: w_hilo = HS_HI;
               FN_MFLO: w_hilo = HS_LO;
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_code = ALU_ADD;
               default: w_illegal = valid_in;
            endcase
         end
         default: w_code = ALU_ADD;
      endcase
   end

   assign w_md_op  = w_rtype & is_md_funct(function_code);
   assign w_accept = valid_in & w_md_op & ~w_busy;

   md_seq #(.DATA_W(DATA_W)) u_md_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_accept),
      .i_is_div    (function_code[1]),
      .i_is_signed (~function_code[0]),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .o_busy      (w_busy),
      .o_md_done   (md_done),
      .o_hi        (hi),
      .o_lo        (lo)
   );

   // Busy alone holds the issuing stage, which also covers HI/LO reads and md ops issued while busy.
   assign stall    = w_accept | w_busy;
   assign alu_ctr  = CTRL_W'(w_code);
   assign illegal  = w_illegal;
   assign hilo_sel = w_hilo;

endmodule

// File: tb/tb_alu_control_md.sv
// tb/tb_alu_control_md.sv - scoreboard bench for alu_control_md
module tb_alu_control_md;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_in = 1'b0;
   logic [2:0]   ALUop = 3'b000;
   logic [5:0]   function_code = 6'h00;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic [3:0]   alu_ctr;
   logic         illegal;
   logic [1:0]   hilo_sel;
   logic         stall;
   logic         md_done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   alu_control_md #(.DATA_W(W), .CTRL_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_in      (valid_in),
      .ALUop         (ALUop),
      .function_code (function_code),
      .op_a          (op_a),
      .op_b          (op_b),
      .alu_ctr       (alu_ctr),
      .illegal       (illegal),
      .hilo_sel      (hilo_sel),
      .stall         (stall),
      .md_done       (md_done),
      .hi            (hi),
      .lo            (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int           cyc;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } md_exp_t;

   typedef struct {
      logic [3:0] ctr;
      logic       ill;
      logic [1:0] hs;
      logic       st;
   } dec_exp_t;

   md_exp_t  md_q[$];
   dec_exp_t dec_q[$];
   logic     dec_chk = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      md_exp_t  e;
      dec_exp_t d;
      if (rst_n && md_done) begin
         if (md_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL md_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = md_q.pop_front();
            chk("md_done_cycle", 64'(cyc), 64'(e.cyc));
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
         end
      end
      if (dec_chk && dec_q.size() != 0) begin
         d = dec_q.pop_front();
         chk("alu_ctr", alu_ctr, d.ctr);
         chk("illegal", illegal, d.ill);
         chk("hilo_sel", hilo_sel, d.hs);
         chk("dec_stall", stall, d.st);
      end
   end

   task automatic dec_vec(input logic v, input logic [2:0] op, input logic [5:0] f,
                          input logic [3:0] ctr, input logic ill, input logic [1:0] hs);
      dec_exp_t d;
      @(posedge clk); #1;
      valid_in = v;
      ALUop = op;
      function_code = f;
      d.ctr = ctr; d.ill = ill; d.hs = hs; d.st = 1'b0;
      dec_q.push_back(d);
      dec_chk = 1'b1;
      @(negedge clk); #1;
      dec_chk = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic start_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat,
                           output int t, output logic st0);
      md_exp_t e;
      @(posedge clk); #1;
      valid_in = 1'b1;
      ALUop = 3'b111;
      function_code = f;
      op_a = a;
      op_b = b;
      t = cyc;
      e.cyc = t + lat; e.hi = ehi; e.lo = elo;
      md_q.push_back(e);
      @(negedge clk);
      st0 = stall;
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input int lat);
      int   t;
      int   ns;
      int   k;
      logic st0;
      start_md(f, a, b, ehi, elo, lat, t, st0);
      ns = st0 ? 1 : 0;
      k = 0;
      while (!md_done && k < 200) begin
         @(negedge clk);
         if (stall) ns++;
         k++;
      end
      if (k >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: got no md_done expected md_done within 200 cycles", name);
      end
      chk({name, "_stall_cycles"}, 64'(ns), 64'(lat));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   t;
      int   k;
      int   ndone;
      logic st0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", stall, 0);
      chk("reset_md_done", md_done, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      rst_n = 1'b1;

      dec_vec(1, 3'b000, 6'h10, 4'b0010, 0, 2'b00);
      dec_vec(1, 3'b001, 6'h00, 4'b0110, 0, 2'b00);
      dec_vec(1, 3'b010, 6'h00, 4'b0000, 0, 2'b00);
      dec_vec(1, 3'b011, 6'h00, 4'b0001, 0, 2'b00);
      dec_vec(1, 3'b100, 6'h00, 4'b0111, 0, 2'b00);
      dec_vec(1, 3'b101, 6'h00, 4'b0011, 0, 2'b00);
      dec_vec(1, 3'b110, 6'h3F, 4'b0010, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h20, 4'b0010, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h21, 4'b0010, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h22, 4'b0110, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h23, 4'b0110, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h24, 4'b0000, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h25, 4'b0001, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h26, 4'b0011, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h27, 4'b1100, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h2A, 4'b0111, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h2B, 4'b1000, 0, 2'b00);
      dec_vec(1, 3'b111, 6'h10, 4'b0010, 0, 2'b01);
      dec_vec(1, 3'b111, 6'h12, 4'b0010, 0, 2'b10);
      dec_vec(1, 3'b111, 6'h3F, 4'b0010, 1, 2'b00);
      dec_vec(0, 3'b111, 6'h3F, 4'b0010, 0, 2'b00);
      dec_vec(0, 3'b111, 6'h18, 4'b0010, 0, 2'b00);

      run_md("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
      run_md("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 34);
      run_md("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      run_md("div_zero", 6'h1A, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 2);
      run_md("div_minneg", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);

      start_md(6'h19, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 34, t, st0);
      chk("multu_accept_stall", st0, 1);
      repeat (4) @(posedge clk);
      #1;
      valid_in = 1'b1;
      ALUop = 3'b111;
      function_code = 6'h12;
      @(negedge clk);
      chk("mflo_busy_stall", stall, 1);
      k = 0;
      while (stall && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("mflo_release_cycle", 64'(cyc), 64'(t + 34));
      chk("mflo_md_done", md_done, 1);
      chk("mflo_hilo_sel", hilo_sel, 2'b10);
      chk("mflo_lo", lo, 32'hFFFF_FFFE);
      chk("mflo_hi", hi, 32'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;

      start_md(6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, t, st0);
      repeat (9) @(posedge clk);
      #2;
      chk("pre_reset_stall", stall, 1);
      rst_n = 1'b0;
      void'(md_q.pop_back());
      #1;
      chk("async_reset_stall", stall, 0);
      chk("async_reset_hi", hi, 0);
      chk("async_reset_lo", lo, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_done) ndone++;
      end
      chk("reset_no_md_done", 64'(ndone), 0);
      run_md("mult_after_reset", 6'h18, 32'd5, 32'd6, 32'd0, 32'd30, 34);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 64'(md_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle MIPS ALU control decoder.
- Decodes ALUop/function into a CTRL_W-bit ALU control word, and adds new I-type and R-type operations.
- Owns an iterative multiply/divide sequencer with HI/LO registers, a pipeline stall interlock and MFHI/MFLO result steering.
- Sits between the main control unit and the datapath ALU / writeback mux.

Parameters:
- DATA_W, 32, operand and HI/LO width; must be at least 4.
- CTRL_W, 4, ALU control word width; must be at least 4. Upper bits above [3:0] are tied to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  decode inputs carry a real instruction this cycle.
- ALUop  in  3  main-control operation class.
- function_code  in  6  R-type funct field.
- op_a  in  DATA_W  rs operand (multiplicand/dividend).
- op_b  in  DATA_W  rt operand (multiplier/divisor).
- alu_ctr  out  CTRL_W  ALU control word (combinational).
- illegal  out  1  unsupported R-type funct with valid_in.
- hilo_sel  out  2  writeback select: 00 ALU, 01 HI, 10 LO.
- stall  out  1  hold the issuing stage.
- md_done  out  1  one-cycle pulse; HI/LO were just updated.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state IDLE, hi=0, lo=0, md_done=0, stall=0.
- ALU codes: AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110, SLT=0111, SLTU=1000, NOR=1100.
- ALUop decode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR, 110 ADD.
  - 111 means R-type, decoded on funct.
- R-type funct decode:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU.
  - 0x10 MFHI (hilo_sel=01); 0x12 MFLO (hilo_sel=10).
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU: md ops, alu_ctr=ADD.
  - Any other funct: alu_ctr=ADD, illegal=valid_in.
- Decode outputs are purely combinational. hilo_sel=00 unless the funct is MFHI/MFLO under R-type.
- Sequencer states: IDLE, MUL, DIV, FIX.
- Accept: valid_in & R-type & md funct & state==IDLE, in cycle T.
  - Operands are latched at T.
  - Signed ops convert operands to magnitudes; result signs are recorded.
  - Next state is MUL or DIV.
  - DIV/DIVU with op_b==0 goes directly to FIX.
- MUL: shift-add, one multiplier bit per cycle, DATA_W cycles (T+1..T+DATA_W), then FIX.
- DIV: restoring division, one quotient bit per cycle, DATA_W cycles, then FIX.
- FIX (one cycle):
  - Applies sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - At the closing edge it writes hi=product[2*DATA_W-1:DATA_W] / remainder and lo=product[DATA_W-1:0] / quotient.
  - Divide-by-zero: hi=op_a as latched, lo=all ones.
  - Next state IDLE; md_done=1 in the following cycle only.
- Latency:
  - Normal op: HI/LO visible and md_done high at T+DATA_W+2.
  - Divide-by-zero: HI/LO visible and md_done high at T+2.
- stall:
  - Combinationally 1 in accept cycle T and every cycle while state != IDLE.
  - Also 1 when valid_in & (MFHI/MFLO or md op) while state != IDLE.
  - Upstream holds instruction and operands while stalled.
  - An op issued during busy is accepted in the first IDLE cycle, which is the md_done cycle.
- MFHI/MFLO in the md_done cycle sees the new HI/LO values, with no stall.
- Most negative dividend / -1: quotient wraps to the most negative value, remainder 0, no exception.
- valid_in=0: no accept, no illegal, no stall contribution.
- Reset mid-operation aborts immediately: hi/lo cleared, no md_done.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU control code constants;
  - ALUop class constants;
  - funct constants;
  - hilo_sel encodings;
  - sequencer state enum.
- One sub-module, md_seq: the iterative multiply/divide datapath, its FSM and the HI/LO registers.
- The decode logic stays in the top module.

Test Plan:
- Full decode sweep of all ALUop values and every listed funct with valid_in=1: funct 0x2A gives alu_ctr=0111; funct 0x3F gives illegal=1, alu_ctr=0010; ALUop=101 gives 0011.
- MULT op_a=-3, op_b=7: stall for 34 cycles, then md_done with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU op_a=100, op_b=7: lo=14, hi=2 at T+34. DIV op_a=-7, op_b=2: lo=-3, hi=-1.
- DIV op_b=0, op_a=0x1234: md_done at T+2, hi=0x1234, lo=0xFFFFFFFF.
- MFLO issued at T+5 of a MULTU 0xFFFFFFFF×2: held stalled until md_done, then hilo_sel=10, lo=0xFFFFFFFE, hi=1.
- rst_n pulsed low at T+10 of a MULT: stall drops asynchronously, hi=lo=0, no md_done; a fresh MULT 5×6 then gives lo=30.
